// File: rtl/uart_rx_os16.sv
// 16x oversampling UART receiver: 2-flop synchroniser, 2-of-3 majority vote per bit,
// optional odd/even parity, stop-bit check and a one-cycle valid strobe per frame.
module uart_rx_os16 #(
  parameter int OS_DIV = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic [1:0] sel,
  output logic [7:0] RX_dataout,
  output logic       rx_valid,
  output logic       parity_error,
  output logic       stop_error,
  output logic       rx_busy
);
  localparam int CW = $clog2(OS_DIV);

  typedef enum logic [2:0] {ARM, IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_nx;

  logic          rx_meta, rxs;
  logic [CW-1:0] pre;
  logic [3:0]    tix;
  logic [1:0]    smp;
  logic [7:0]    shreg;
  logic [2:0]    bitn;
  logic [1:0]    sel_q;
  logic          perr_q;

  logic tick, decide, bit_end, vote, par_on, exp_par, start_det;

  assign tick    = (pre == CW'(OS_DIV - 1));
  assign decide  = tick && (tix == 4'd9);
  assign bit_end = tick && (tix == 4'd15);
  assign vote    = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
  assign par_on  = (sel_q == 2'b01) || (sel_q == 2'b10);
  assign exp_par = (^shreg) ^ (sel_q == 2'b01);

  always_ff @(posedge clk) begin
    if (reset) state <= ARM;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start_det = 1'b0;
    case (state)
      ARM:    if (rxs) state_nx = IDLE;
      IDLE:   if (!rxs) begin
                start_det = 1'b1;
                state_nx  = START;
              end
      START:  if (decide && vote) state_nx = IDLE;
              else if (bit_end)   state_nx = DATA;
      DATA:   if (bit_end && bitn == 3'd7) state_nx = par_on ? PARITY : STOP;
      PARITY: if (bit_end) state_nx = STOP;
      // Leave at mid-stop-bit so the next start edge is caught without slip.
      STOP:   if (decide) state_nx = vote ? IDLE : ARM;
      default: state_nx = ARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta      <= 1'b0;
      rxs          <= 1'b0;
      pre          <= '0;
      tix          <= '0;
      smp          <= '0;
      shreg        <= '0;
      bitn         <= '0;
      sel_q        <= '0;
      perr_q       <= 1'b0;
      RX_dataout   <= '0;
      rx_valid     <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rxs      <= rx_meta;
      rx_valid <= 1'b0;

      if (start_det || tick) pre <= '0;
      else                   pre <= pre + CW'(1);

      if (start_det) tix <= '0;
      else if (tick) tix <= tix + 4'd1;

      if (tick && tix == 4'd7) smp[0] <= rxs;
      if (tick && tix == 4'd8) smp[1] <= rxs;

      if (start_det) begin
        sel_q   <= sel;
        rx_busy <= 1'b1;
        bitn    <= '0;
        perr_q  <= 1'b0;
      end

      if (state == START && decide && vote) rx_busy <= 1'b0;

      if (state == DATA && decide)  shreg <= {vote, shreg[7:1]};
      if (state == DATA && bit_end) bitn  <= bitn + 3'd1;

      if (state == PARITY && decide) perr_q <= (vote != exp_par);

      if (state == STOP && decide) begin
        RX_dataout   <= shreg;
        parity_error <= par_on & perr_q;
        stop_error   <= ~vote;
        rx_valid     <= 1'b1;
        rx_busy      <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: directed frame table, corner sequences and randomized
// frames (incl. +/-3% baud skew) checked against a frame-level reference model.
module tb_uart_rx_os16;
  localparam int OSD = 4;
  localparam int BC  = 16 * OSD;

  logic       clk = 1'b0;
  logic       reset, rx;
  logic [1:0] sel;
  logic [7:0] RX_dataout;
  logic       rx_valid, parity_error, stop_error, rx_busy;

  uart_rx_os16 #(.OS_DIV(OSD)) dut (
    .clk(clk), .reset(reset), .rx(rx), .sel(sel),
    .RX_dataout(RX_dataout), .rx_valid(rx_valid), .parity_error(parity_error),
    .stop_error(stop_error), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       se;
  } res_t;

  typedef struct {
    logic [1:0] s;
    logic [7:0] d;
    logic       pb;
    logic       sb;
    res_t       exp;
  } vec_t;

  res_t got_q[$];
  res_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always @(negedge clk)
    if (!reset && rx_valid) got_q.push_back(res_t'({RX_dataout, parity_error, stop_error}));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic line_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Serial transmitter; sel is scrambled mid-frame to prove it is latched at start.
  task automatic send_frame(input logic [1:0] s, input logic [7:0] d, input logic pb,
                            input logic sb, input int bc);
    sel = s;
    line_bit(1'b0, bc);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) sel = 2'($urandom);
      line_bit(d[i], bc);
    end
    if (s == 2'b01 || s == 2'b10) line_bit(pb, bc);
    line_bit(sb, bc);
    rx = 1'b1;
  endtask

  function automatic res_t model(input logic [1:0] s, input logic [7:0] d,
                                 input logic pb, input logic sb);
    res_t r;
    logic want;
    want = (s == 2'b10) ? (^d) : ~(^d);
    r.d  = d;
    r.pe = (s == 2'b01 || s == 2'b10) ? (pb != want) : 1'b0;
    r.se = ~sb;
    return r;
  endfunction

  task automatic drain(input string tag);
    res_t g, e;
    repeat (150) @(negedge clk);
    chk({tag, " strobes"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, " data"}, g.d, e.d);
      chk({tag, " parity_error"}, g.pe, e.pe);
      chk({tag, " stop_error"}, g.se, e.se);
    end
    got_q.delete();
    exp_q.delete();
    chk({tag, " busy idle"}, rx_busy, 1'b0);
  endtask

  vec_t vt[$];

  initial begin
    vt.push_back('{2'b00, 8'hA5, 1'b0, 1'b1, '{8'hA5, 1'b0, 1'b0}});
    vt.push_back('{2'b10, 8'hAA, 1'b0, 1'b1, '{8'hAA, 1'b0, 1'b0}});
    vt.push_back('{2'b10, 8'hAA, 1'b1, 1'b1, '{8'hAA, 1'b1, 1'b0}});
    vt.push_back('{2'b01, 8'h01, 1'b0, 1'b1, '{8'h01, 1'b0, 1'b0}});
    vt.push_back('{2'b01, 8'h03, 1'b0, 1'b1, '{8'h03, 1'b1, 1'b0}});
    vt.push_back('{2'b11, 8'h96, 1'b0, 1'b1, '{8'h96, 1'b0, 1'b0}});
    vt.push_back('{2'b10, 8'h7E, 1'b1, 1'b0, '{8'h7E, 1'b1, 1'b1}});

    reset = 1'b1; rx = 1'b1; sel = 2'b00;
    repeat (5) @(negedge clk);
    chk("reset RX_dataout", RX_dataout, 8'h00);
    chk("reset rx_valid", rx_valid, 1'b0);
    chk("reset parity_error", parity_error, 1'b0);
    chk("reset stop_error", stop_error, 1'b0);
    chk("reset rx_busy", rx_busy, 1'b0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    foreach (vt[i]) begin
      exp_q.push_back(vt[i].exp);
      send_frame(vt[i].s, vt[i].d, vt[i].pb, vt[i].sb, BC);
      repeat (12) @(negedge clk);
      drain("table");
    end

    // Short low glitch: busy rises, then the vote rejects it.
    rx = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch busy high", rx_busy, 1'b1);
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    chk("glitch busy low", rx_busy, 1'b0);
    chk("glitch no strobe", got_q.size(), 0);
    exp_q.push_back(model(2'b00, 8'h5A, 1'b0, 1'b1));
    send_frame(2'b00, 8'h5A, 1'b0, 1'b1, BC);
    drain("after glitch");

    // Break: one errored all-zero frame, then silence until the line returns high.
    sel = 2'b00;
    line_bit(1'b0, 700);
    chk("break busy low", rx_busy, 1'b0);
    line_bit(1'b0, 12 * BC - 700);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    exp_q.push_back('{8'h00, 1'b0, 1'b1});
    exp_q.push_back(model(2'b00, 8'h3C, 1'b0, 1'b1));
    send_frame(2'b00, 8'h3C, 1'b0, 1'b1, BC);
    drain("break");

    // Reset during data bit 4 of 0xFF, then two back-to-back frames.
    sel = 2'b00;
    line_bit(1'b0, BC);
    for (int i = 0; i < 4; i++) line_bit(1'b1, BC);
    line_bit(1'b1, BC / 2);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset RX_dataout", RX_dataout, 8'h00);
    chk("midreset rx_valid", rx_valid, 1'b0);
    chk("midreset parity_error", parity_error, 1'b0);
    chk("midreset stop_error", stop_error, 1'b0);
    chk("midreset rx_busy", rx_busy, 1'b0);
    reset = 1'b0;
    rx = 1'b1;
    repeat (40) @(negedge clk);
    exp_q.push_back(model(2'b00, 8'h11, 1'b0, 1'b1));
    exp_q.push_back(model(2'b00, 8'h22, 1'b0, 1'b1));
    send_frame(2'b00, 8'h11, 1'b0, 1'b1, BC);
    send_frame(2'b00, 8'h22, 1'b0, 1'b1, BC);
    drain("back2back");

    // Random frames with baud skew of -3%, 0, +3%.
    for (int n = 0; n < 40; n++) begin
      logic [1:0] s;
      logic [7:0] d;
      logic       pb, sb;
      int         bc, gap;
      s   = 2'($urandom);
      d   = 8'($urandom);
      pb  = 1'($urandom);
      sb  = ($urandom_range(0, 7) != 0);
      bc  = (n % 3 == 0) ? 62 : (n % 3 == 1) ? 64 : 66;
      gap = sb ? $urandom_range(0, 20) : $urandom_range(10, 20);
      exp_q.push_back(model(s, d, pb, sb));
      send_frame(s, d, pb, sb, bc);
      repeat (gap) @(negedge clk);
    end
    drain("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
